// File: rtl/ntt_operand_feeder_if.sv
// Operand bus from the NTT issue stage to the butterfly, with a ready/valid handshake.
interface ntt_operand_feeder_if #(
    parameter int unsigned LOGN = 8,
    parameter int unsigned Q_W  = 23
);
    logic            valid_o;
    logic            ready_i;
    logic [Q_W:0]    a_o;
    logic [Q_W:0]    b_o;
    logic [Q_W-1:0]  twiddle_o;
    logic            sel_butterfly_o;
    logic            sel_red_o;
    logic [LOGN-1:0] wr_addr_a_o;
    logic [LOGN-1:0] wr_addr_b_o;

    modport master (
        output valid_o, a_o, b_o, twiddle_o, sel_butterfly_o, sel_red_o,
               wr_addr_a_o, wr_addr_b_o,
        input  ready_i
    );

    modport slave (
        input  valid_o, a_o, b_o, twiddle_o, sel_butterfly_o, sel_red_o,
               wr_addr_a_o, wr_addr_b_o,
        output ready_i
    );
endinterface

// File: rtl/ntt_operand_feeder.sv
// NTT issue stage: walks all stages of a CT/GS transform, reads coefficient pairs and twiddles,
// and presents aligned operand sets to the butterfly behind a ready/valid handshake with a 1-entry skid.
module ntt_operand_feeder #(
    parameter int unsigned LOGN     = 8,
    parameter int unsigned Q_W      = 23,
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            mode_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            rd_en_o,
    output logic [LOGN-1:0] rd_addr_a_o,
    output logic [LOGN-1:0] rd_addr_b_o,
    output logic [LOGN-1:0] tw_addr_o,
    input  logic [Q_W-1:0]  rd_data_a_i,
    input  logic [Q_W-1:0]  rd_data_b_i,
    input  logic [Q_W-1:0]  tw_data_i,
    ntt_operand_feeder_if.master op
);
    localparam int unsigned N     = 1 << LOGN;
    localparam int unsigned PAIRS = N / 2;
    localparam int unsigned SW    = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int unsigned DW    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int unsigned CW    = LOGN;
    localparam int unsigned OW    = 1 + 2 * LOGN + Q_W + 2 * (Q_W + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state;
    logic [SW-1:0]   stage;
    logic [CW-1:0]   p_cnt;
    logic [CW-1:0]   x_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            mode_r;
    logic            inflight_valid;
    logic            inflight_red;
    logic [LOGN-1:0] inflight_wa;
    logic [LOGN-1:0] inflight_wb;
    logic            skid_valid;
    logic [OW-1:0]   skid;
    logic [OW-1:0]   arrival;
    logic            xfer;

    // Returns {tw_addr, rd_addr_b, rd_addr_a} for pair p of stage s.
    function automatic logic [3*LOGN-1:0] pair_addr(input logic [SW-1:0] s,
                                                    input logic [CW-1:0] p,
                                                    input logic inv);
        int unsigned lg, len, blk, off, a, tw;
        lg  = inv ? 32'(s) : (LOGN - 1 - 32'(s));
        len = 32'(1) << lg;
        blk = 32'(p) >> lg;
        off = 32'(p) & (len - 1);
        a   = (blk << (lg + 1)) | off;
        tw  = inv ? ((N >> lg) - 1 - blk) : ((N >> (lg + 1)) + blk);
        return {LOGN'(tw), LOGN'(a + len), LOGN'(a)};
    endfunction

    assign rd_en_o = (state == ISSUE) && (p_cnt < CW'(PAIRS)) && !skid_valid
                     && !(op.valid_o && !op.ready_i);
    assign xfer    = op.valid_o && op.ready_i;
    assign arrival = {inflight_red, inflight_wb, inflight_wa, tw_data_i,
                      1'b0, rd_data_b_i, 1'b0, rd_data_a_i};
    assign op.sel_butterfly_o = mode_r;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            stage          <= '0;
            p_cnt          <= '0;
            x_cnt          <= '0;
            drain_cnt      <= '0;
            mode_r         <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            rd_addr_a_o    <= '0;
            rd_addr_b_o    <= '0;
            tw_addr_o      <= '0;
            inflight_valid <= 1'b0;
            inflight_red   <= 1'b0;
            inflight_wa    <= '0;
            inflight_wb    <= '0;
            skid_valid     <= 1'b0;
            skid           <= '0;
            op.valid_o     <= 1'b0;
            {op.sel_red_o, op.wr_addr_b_o, op.wr_addr_a_o, op.twiddle_o, op.b_o, op.a_o} <= '0;
        end else begin
            done_o         <= 1'b0;
            inflight_valid <= rd_en_o;

            // Issue side: capture the sideband of this read and precompute the next pair's addresses.
            if (rd_en_o) begin
                inflight_wa  <= rd_addr_a_o;
                inflight_wb  <= rd_addr_b_o;
                inflight_red <= (stage == SW'(LOGN - 1));
                p_cnt        <= p_cnt + CW'(1);
                {tw_addr_o, rd_addr_b_o, rd_addr_a_o} <= pair_addr(stage, p_cnt + CW'(1), mode_r);
            end

            // Output side: the skid always holds the older operand set, so it drains first.
            if (!op.valid_o || op.ready_i) begin
                if (skid_valid) begin
                    op.valid_o <= 1'b1;
                    {op.sel_red_o, op.wr_addr_b_o, op.wr_addr_a_o, op.twiddle_o, op.b_o, op.a_o} <= skid;
                    skid_valid <= inflight_valid;
                    if (inflight_valid) skid <= arrival;
                end else if (inflight_valid) begin
                    op.valid_o <= 1'b1;
                    {op.sel_red_o, op.wr_addr_b_o, op.wr_addr_a_o, op.twiddle_o, op.b_o, op.a_o} <= arrival;
                end else begin
                    op.valid_o <= 1'b0;
                end
            end else if (inflight_valid) begin
                skid_valid <= 1'b1;
                skid       <= arrival;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state  <= ISSUE;
                        busy_o <= 1'b1;
                        mode_r <= mode_i;
                        stage  <= '0;
                        p_cnt  <= '0;
                        x_cnt  <= '0;
                        {tw_addr_o, rd_addr_b_o, rd_addr_a_o} <= pair_addr(SW'(0), CW'(0), mode_i);
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        if (x_cnt == CW'(PAIRS - 1)) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            x_cnt <= x_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Hold off the next stage until the butterfly has written this stage back.
                    if (drain_cnt == DW'(PIPE_LAT - 1)) begin
                        if (stage == SW'(LOGN - 1)) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            state <= ISSUE;
                            stage <= stage + SW'(1);
                            p_cnt <= '0;
                            x_cnt <= '0;
                            {tw_addr_o, rd_addr_b_o, rd_addr_a_o} <= pair_addr(stage + SW'(1), CW'(0), mode_r);
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_operand_feeder.sv
// Scoreboard bench for ntt_operand_feeder: expected reads/operand sets are queued at start and
// checked by a negedge monitor against a coefficient RAM / twiddle ROM model.
module tb_ntt_operand_feeder;
    localparam int unsigned LOGN     = 8;
    localparam int unsigned Q_W      = 23;
    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned N        = 256;
    localparam int unsigned PAIRS    = 128;
    localparam int unsigned TOTAL    = 1024;

    typedef struct packed {
        logic [LOGN-1:0] a;
        logic [LOGN-1:0] b;
        logic [LOGN-1:0] tw;
        logic            red;
    } exp_t;

    typedef struct {
        int mode, s, p, a, b, tw;
    } dir_t;

    logic clk = 1'b0;
    logic rst, start, mode;
    logic busy, done, rd_en;
    logic [LOGN-1:0] rd_addr_a, rd_addr_b, tw_addr;
    logic [Q_W-1:0]  rd_a, rd_b, tw_d;

    ntt_operand_feeder_if #(.LOGN(LOGN), .Q_W(Q_W)) op();

    ntt_operand_feeder #(.LOGN(LOGN), .Q_W(Q_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .busy_o(busy), .done_o(done), .rd_en_o(rd_en),
        .rd_addr_a_o(rd_addr_a), .rd_addr_b_o(rd_addr_b), .tw_addr_o(tw_addr),
        .rd_data_a_i(rd_a), .rd_data_b_i(rd_b), .tw_data_i(tw_d),
        .op(op)
    );

    always #5 clk = ~clk;

    logic [Q_W-1:0] coef [N];
    logic [Q_W-1:0] twr  [N];
    exp_t rd_q[$];
    exp_t xf_q[$];
    dir_t dir[6];

    int total = 0, bad = 0;
    int cyc = 0, rd_idx = 0, xf_idx = 0, done_cnt = 0;
    int first_rd_cyc = 0, last_xfer_cyc = 0;
    logic cur_mode = 1'b0, rand_ready = 1'b0, lat_chk = 1'b0, prev_stall = 1'b0;
    logic [88:0] prev_tuple = '0;

    // RAM/ROM model: synchronous read, data one cycle after rd_en.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            rd_a <= coef[rd_addr_a];
            rd_b <= coef[rd_addr_b];
            tw_d <= twr[tw_addr];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [88:0] out_tuple();
        return {op.sel_red_o, op.sel_butterfly_o, op.wr_addr_a_o, op.wr_addr_b_o,
                op.a_o, op.b_o, op.twiddle_o};
    endfunction

    // Reference walk written as the textbook nested block/offset loops.
    task automatic push_expected(input logic inv);
        exp_t e;
        for (int s = 0; s < int'(LOGN); s++) begin
            int len;
            int k;
            len = inv ? (1 << s) : (int'(N) >> (s + 1));
            k = 0;
            for (int st = 0; st < int'(N); st += 2 * len) begin
                for (int j = 0; j < len; j++) begin
                    e.a   = LOGN'(st + j);
                    e.b   = LOGN'(st + j + len);
                    e.tw  = inv ? LOGN'(int'(N) / len - 1 - k) : LOGN'(int'(N) / (2 * len) + k);
                    e.red = (s == int'(LOGN) - 1);
                    rd_q.push_back(e);
                    xf_q.push_back(e);
                end
                k++;
            end
        end
    endtask

    // Ready driver.
    initial begin
        op.ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            op.ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: reads, transfers, stall hold, done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_q.delete();
                xf_q.delete();
                rd_idx = 0; xf_idx = 0; done_cnt = 0; prev_stall = 1'b0;
            end else begin
                if (start) begin
                    rd_idx = 0; xf_idx = 0; done_cnt = 0;
                end
                if (prev_stall)
                    check("stall_hold", {op.valid_o, out_tuple()}, {1'b1, prev_tuple});
                if (rd_en) begin
                    check("busy_on_read", busy, 1'b1);
                    if (rd_q.size() == 0) begin
                        check("read_extra", 1'b1, 1'b0);
                    end else begin
                        e = rd_q.pop_front();
                        check($sformatf("read%0d", rd_idx), {rd_addr_a, rd_addr_b, tw_addr},
                              {e.a, e.b, e.tw});
                    end
                    for (int i = 0; i < 6; i++)
                        if (dir[i].mode == int'(cur_mode) && dir[i].s == rd_idx / int'(PAIRS)
                            && dir[i].p == rd_idx % int'(PAIRS))
                            check($sformatf("dir%0d", i), {rd_addr_a, rd_addr_b, tw_addr},
                                  {LOGN'(dir[i].a), LOGN'(dir[i].b), LOGN'(dir[i].tw)});
                    if (rd_idx > 0 && rd_idx % int'(PAIRS) == 0)
                        check("stage_gap", (cyc - last_xfer_cyc) >= int'(PIPE_LAT), 1'b1);
                    if (rd_idx == 0) first_rd_cyc = cyc;
                    rd_idx++;
                end
                if (op.valid_o && op.ready_i) begin
                    check("busy_on_xfer", busy, 1'b1);
                    if (xf_q.size() == 0) begin
                        check("xfer_extra", 1'b1, 1'b0);
                    end else begin
                        e = xf_q.pop_front();
                        check($sformatf("xfer%0d", xf_idx), out_tuple(),
                              {e.red, cur_mode, e.a, e.b, 1'b0, coef[e.a], 1'b0, coef[e.b], twr[e.tw]});
                    end
                    if (xf_idx == 0 && lat_chk) check("first_latency", cyc - first_rd_cyc, 2);
                    if (!cur_mode && xf_idx == int'(TOTAL) - 1) check("red_last", op.sel_red_o, 1'b1);
                    if (!cur_mode && xf_idx == int'(TOTAL - PAIRS) - 1) check("red_s6", op.sel_red_o, 1'b0);
                    last_xfer_cyc = cyc;
                    xf_idx++;
                end
                if (done) begin
                    done_cnt++;
                    check("done_gap", cyc - last_xfer_cyc, PIPE_LAT + 1);
                end
                prev_stall = op.valid_o && !op.ready_i;
                prev_tuple = out_tuple();
            end
        end
    end

    task automatic run(input logic m, input logic rnd);
        logic ok;
        push_expected(m);
        cur_mode   = m;
        rand_ready = rnd;
        lat_chk    = !rnd;
        @(posedge clk); #1;
        start = 1'b1; mode = m;
        @(posedge clk); #1;
        start = 1'b0; mode = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        check("done_timeout", ok, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("xfer_count", xf_idx, TOTAL);
        check("read_count", rd_idx, TOTAL);
        check("done_pulses", done_cnt, 1);
        check("queues_empty", rd_q.size() + xf_q.size(), 0);
        check("idle_after", {busy, op.valid_o, rd_en}, 3'b000);
    endtask

    initial begin
        logic ok;
        for (int i = 0; i < int'(N); i++) begin
            coef[i] = Q_W'((i * 40503 + 17) % 8380417);
            twr[i]  = Q_W'((i * 7919 + 3) % 8380417);
        end
        dir[0] = '{0, 0, 0,   0,   128, 1};
        dir[1] = '{0, 0, 1,   1,   129, 1};
        dir[2] = '{0, 1, 64,  128, 192, 3};
        dir[3] = '{0, 7, 127, 254, 255, 255};
        dir[4] = '{1, 0, 0,   0,   1,   255};
        dir[5] = '{1, 0, 127, 254, 255, 128};

        rst = 1'b1; start = 1'b0; mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, op.valid_o, out_tuple()}, '0);
        rst = 1'b0;

        run(1'b0, 1'b0);
        run(1'b1, 1'b1);
        run(1'b0, 1'b1);

        // Abort in the middle of stage 3, then replay from scratch.
        push_expected(1'b0);
        cur_mode = 1'b0; rand_ready = 1'b0; lat_chk = 1'b1;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (xf_idx >= int'(3 * PAIRS) + 20) begin ok = 1'b1; break; end
        end
        check("abort_reach", ok, 1'b1);
        check("abort_no_done", done_cnt, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_clear", {op.valid_o, busy, done, rd_en}, 4'b0000);
        repeat (6) @(posedge clk);
        #1;
        check("abort_quiet", {op.valid_o, busy, done}, 3'b000);
        run(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
